// File: rtl/ad_ip_jesd204_tpl_dac_src_seq_if.sv
// Control and status bundle for the DAC source sequencer.
// The master side programs the table and issues start/stop; the slave side is the sequencer.
interface ad_ip_jesd204_tpl_dac_src_seq_if #(
   parameter int NUM_ENTRIES = 4,
   parameter int DWELL_WIDTH = 16
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   logic                   cfg_we;
   logic [IDX_W-1:0]       cfg_addr;
   logic [3:0]             cfg_sel;
   logic [DWELL_WIDTH-1:0] cfg_dwell;
   logic [IDX_W-1:0]       cfg_last;
   logic                   loop_en;
   logic                   start;
   logic                   stop;
   logic [3:0]             dac_data_sel;
   logic                   dac_data_sync;
   logic [IDX_W-1:0]       entry_idx;
   logic                   busy;
   logic                   done;

   modport master (
      output cfg_we, cfg_addr, cfg_sel, cfg_dwell, cfg_last, loop_en, start, stop,
      input  dac_data_sel, dac_data_sync, entry_idx, busy, done
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_sel, cfg_dwell, cfg_last, loop_en, start, stop,
      output dac_data_sel, dac_data_sync, entry_idx, busy, done
   );
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_src_seq.sv
// DAC source sequencer: steps through a table of {source select, dwell} entries,
// pulsing a phase sync on each entry change and a done pulse at the end of a pass.
module ad_ip_jesd204_tpl_dac_src_seq #(
   parameter int NUM_ENTRIES = 4,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              resetn,
   ad_ip_jesd204_tpl_dac_src_seq_if.slave    bus
);
   localparam int         IDX_W    = $clog2(NUM_ENTRIES);
   localparam logic [3:0] SEL_ZERO = 4'h3;

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_DONE} state_t;

   // A zero dwell still occupies one RUN cycle.
   function automatic logic [DWELL_WIDTH-1:0] f_dwell_load(input logic [DWELL_WIDTH-1:0] d);
      return (d == '0) ? DWELL_WIDTH'(1) : d;
   endfunction

   state_t                 r_state;
   logic [3:0]             r_sel;
   logic                   r_sync;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_busy;
   logic                   r_done;
   logic [DWELL_WIDTH-1:0] r_cnt;
   logic [IDX_W-1:0]       r_last;
   logic                   r_loop;
   logic [3:0]             r_tbl_sel   [NUM_ENTRIES];
   logic [DWELL_WIDTH-1:0] r_tbl_dwell [NUM_ENTRIES];

   state_t                 w_state_nxt;
   logic [3:0]             w_sel_nxt;
   logic                   w_sync_nxt;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic                   w_busy_nxt;
   logic                   w_done_nxt;
   logic [DWELL_WIDTH-1:0] w_cnt_nxt;
   logic [IDX_W-1:0]       w_last_nxt;
   logic                   w_loop_nxt;
   logic                   w_enter_sync;
   logic [IDX_W-1:0]       w_seq_idx;

   always_comb begin
      w_state_nxt  = r_state;
      w_sel_nxt    = r_sel;
      w_sync_nxt   = 1'b0;
      w_idx_nxt    = r_idx;
      w_done_nxt   = 1'b0;
      w_cnt_nxt    = r_cnt;
      w_last_nxt   = r_last;
      w_loop_nxt   = r_loop;
      w_enter_sync = 1'b0;
      w_seq_idx    = r_idx;

      case (r_state)
         S_IDLE: begin
            w_sel_nxt = SEL_ZERO;
            if (bus.start && !bus.stop) begin
               w_last_nxt   = bus.cfg_last;
               w_loop_nxt   = bus.loop_en;
               w_seq_idx    = '0;
               w_enter_sync = 1'b1;
            end
         end
         S_SYNC: w_state_nxt = S_RUN;
         S_RUN: begin
            if (r_cnt == DWELL_WIDTH'(1)) begin
               if (r_idx < r_last) begin
                  w_seq_idx    = r_idx + IDX_W'(1);
                  w_enter_sync = 1'b1;
               end else if (r_loop) begin
                  w_seq_idx    = '0;
                  w_enter_sync = 1'b1;
               end else begin
                  w_state_nxt = S_DONE;
                  w_sel_nxt   = SEL_ZERO;
                  w_idx_nxt   = '0;
                  w_cnt_nxt   = '0;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_cnt - DWELL_WIDTH'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = SEL_ZERO;
            w_idx_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = SEL_ZERO;
         end
      endcase

      if (w_enter_sync) begin
         w_state_nxt = S_SYNC;
         w_idx_nxt   = w_seq_idx;
         w_sel_nxt   = r_tbl_sel[w_seq_idx];
         w_cnt_nxt   = f_dwell_load(r_tbl_dwell[w_seq_idx]);
         w_sync_nxt  = 1'b1;
      end

      // Abort wins over every sequencing decision, including the wrap to entry 0.
      if (bus.stop && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
         w_sel_nxt   = SEL_ZERO;
         w_idx_nxt   = '0;
         w_cnt_nxt   = '0;
         w_sync_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
      end

      w_busy_nxt = (w_state_nxt == S_SYNC) || (w_state_nxt == S_RUN);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_sel   <= SEL_ZERO;
         r_sync  <= 1'b0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_last  <= '0;
         r_loop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_sync  <= w_sync_nxt;
         r_idx   <= w_idx_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_cnt   <= w_cnt_nxt;
         r_last  <= w_last_nxt;
         r_loop  <= w_loop_nxt;
      end
   end

   // The table is only writable while idle so a running pass never sees a torn entry.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_tbl_sel[i]   <= SEL_ZERO;
            r_tbl_dwell[i] <= '0;
         end
      end else if (bus.cfg_we && (r_state == S_IDLE)) begin
         r_tbl_sel[bus.cfg_addr]   <= bus.cfg_sel;
         r_tbl_dwell[bus.cfg_addr] <= bus.cfg_dwell;
      end
   end

   assign bus.dac_data_sel  = r_sel;
   assign bus.dac_data_sync = r_sync;
   assign bus.entry_idx     = r_idx;
   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_src_seq.sv
// Bench for the DAC source sequencer: per-cycle expected outputs are queued from the
// table contents when a sequence is launched and compared as the DUT produces them.
module tb_ad_ip_jesd204_tpl_dac_src_seq;
   localparam int NE = 4;
   localparam int DW = 16;
   localparam int IW = $clog2(NE);

   typedef struct packed {
      logic [3:0]    sel;
      logic          sync;
      logic [IW-1:0] idx;
      logic          busy;
      logic          done;
   } exp_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc_no  = 0;

   ad_ip_jesd204_tpl_dac_src_seq_if #(.NUM_ENTRIES(NE), .DWELL_WIDTH(DW)) bus ();

   ad_ip_jesd204_tpl_dac_src_seq #(.NUM_ENTRIES(NE), .DWELL_WIDTH(DW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h, want %0h", tag, cyc_no, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] s, input logic sy, input logic [IW-1:0] i,
                       input logic b, input logic d);
      exp_t e;
      e.sel = s; e.sync = sy; e.idx = i; e.busy = b; e.done = d;
      q.push_back(e);
   endtask

   task automatic push_entry(input logic [3:0] s, input logic [IW-1:0] i, input int dwell);
      push(s, 1'b1, i, 1'b1, 1'b0);
      repeat ((dwell == 0) ? 1 : dwell) push(s, 1'b0, i, 1'b1, 1'b0);
   endtask

   task automatic push_done();
      push(4'h3, 1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic push_idle(input int n);
      repeat (n) push(4'h3, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic cyc();
      exp_t e;
      @(posedge clk);
      #1;
      cyc_no++;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("sel",  32'(bus.dac_data_sel),  32'(e.sel));
         chk("sync", 32'(bus.dac_data_sync), 32'(e.sync));
         chk("idx",  32'(bus.entry_idx),     32'(e.idx));
         chk("busy", 32'(bus.busy),          32'(e.busy));
         chk("done", 32'(bus.done),          32'(e.done));
      end
   endtask

   task automatic drain();
      while (q.size() > 0) cyc();
   endtask

   task automatic write_tbl(input logic [IW-1:0] a, input logic [3:0] s, input logic [DW-1:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_sel   = s;
      bus.cfg_dwell = d;
      push_idle(1);
      cyc();
      bus.cfg_we = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sel"},  32'(bus.dac_data_sel),  32'h3);
      chk({tag, "_sync"}, 32'(bus.dac_data_sync), 32'h0);
      chk({tag, "_idx"},  32'(bus.entry_idx),     32'h0);
      chk({tag, "_busy"}, 32'(bus.busy),          32'h0);
      chk({tag, "_done"}, 32'(bus.done),          32'h0);
   endtask

   task automatic launch();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   initial begin
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_sel = '0; bus.cfg_dwell = '0;
      bus.cfg_last = '0; bus.loop_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("rst");
      resetn = 1'b1;

      // Single pass over two entries
      write_tbl(0, 4'h2, 16'd3);
      write_tbl(1, 4'h0, 16'd2);
      bus.cfg_last = 1; bus.loop_en = 1'b0;
      push_entry(4'h2, 0, 3); push_entry(4'h0, 1, 2); push_done(); push_idle(2);
      launch();
      drain();

      // Zero dwell, plus a start during DONE that must be ignored
      write_tbl(0, 4'h1, 16'd0);
      bus.cfg_last = 0;
      push_entry(4'h1, 0, 0); push_done(); push_idle(3);
      launch();
      cyc(); cyc();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      drain();

      // Looping, then stop exactly at the wrap point
      write_tbl(0, 4'h2, 16'd3);
      bus.cfg_last = 1; bus.loop_en = 1'b1;
      for (int r = 0; r < 3; r++) begin
         push_entry(4'h2, 0, 3);
         push_entry(4'h0, 1, 2);
      end
      launch();
      drain();
      bus.stop = 1'b1;
      push_idle(1);
      cyc();
      bus.stop = 1'b0;
      push_idle(2);
      drain();

      // Stop mid-RUN, then simultaneous start/stop in IDLE
      bus.loop_en = 1'b0;
      push(4'h2, 1'b1, 0, 1'b1, 1'b0);
      push(4'h2, 1'b0, 0, 1'b1, 1'b0);
      launch();
      cyc();
      bus.stop = 1'b1;
      push_idle(1);
      cyc();
      bus.stop = 1'b0;
      push_idle(3);
      drain();
      bus.start = 1'b1; bus.stop = 1'b1;
      push_idle(3);
      cyc();
      bus.start = 1'b0; bus.stop = 1'b0;
      drain();

      // Table write while busy is dropped; a rerun shows the original entry
      push_entry(4'h2, 0, 3); push_entry(4'h0, 1, 2); push_done(); push_idle(2);
      launch();
      bus.cfg_we = 1'b1; bus.cfg_addr = 0; bus.cfg_sel = 4'h7; bus.cfg_dwell = 16'd9;
      repeat (5) cyc();
      bus.cfg_we = 1'b0;
      drain();
      push_entry(4'h2, 0, 3); push_entry(4'h0, 1, 2); push_done(); push_idle(2);
      launch();
      drain();

      // Asynchronous reset mid-sequence
      push_entry(4'h2, 0, 3);
      launch();
      cyc();
      #2;
      resetn = 1'b0;
      #1;
      chk_reset_outputs("arst");
      q.delete();
      @(posedge clk);
      #1;
      chk_reset_outputs("arst_hold");
      resetn = 1'b1;
      push_idle(2);
      cyc(); cyc();
      bus.cfg_last = 0; bus.loop_en = 1'b0;
      push_entry(4'h3, 0, 0); push_done(); push_idle(2);
      launch();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
